// File: rtl/serial_sub_seq.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// reusing a single full-subtractor cell with the borrow held in a flop.
//
// Handshake: start is sampled only when the block is IDLE or DONE. A sampled
// start captures a/b/bin and moves to RUN, where busy is high for exactly
// WIDTH cycles. DONE follows for exactly one cycle with done high. diff/bout
// are valid from that cycle on and hold until the next accepted operation
// starts shifting.

// One-bit full-subtractor cell: d = x - y - c, bo = borrow out.
module serial_sub_cell (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ c;
  assign bo = (~x & y) | (~(x ^ y) & c);
endmodule

module serial_sub_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic [1:0]       state_dbg
);

  // A 1-bit counter is kept for WIDTH=1 so the compare stays well-formed.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            accept;
  logic            last;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic            borrow;
  logic [CW-1:0]   cnt;
  logic            cell_d;
  logic            cell_bo;
  logic [WIDTH-1:0] diff_shift;

  serial_sub_cell u_cell (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .c  (borrow),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // New result bit enters from the MSB side so the LSB ends up at diff[0].
  generate
    if (WIDTH == 1) begin : g_w1
      assign diff_shift = cell_d;
    end else begin : g_wn
      assign diff_shift = {cell_d, diff[WIDTH-1:1]};
    end
  endgenerate

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic plus accept/last strobes for the datapath.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and per-bit shift; bout is only written on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      borrow <= bin;
      cnt    <= '0;
    end else if (state == RUN) begin
      diff   <= diff_shift;
      borrow <= cell_bo;
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      cnt    <= cnt + CW'(1);
      if (last) bout <= cell_bo;
    end
  end

  // Handshake outputs are pure state decodes, so they cannot glitch.
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_serial_sub_seq.sv
// Directed bench for serial_sub_seq: WIDTH=8 main instance and a WIDTH=1
// instance sharing clock and reset.
module tb_serial_sub_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic [1:0] state_dbg;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       bin1;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       bout1;
  logic [1:0] state_dbg1;

  int n_pass;
  int n_total;

  serial_sub_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .bout      (bout),
    .state_dbg (state_dbg)
  );

  serial_sub_seq #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .a         (a1),
    .b         (b1),
    .bin       (bin1),
    .busy      (busy1),
    .done      (done1),
    .diff      (diff1),
    .bout      (bout1),
    .state_dbg (state_dbg1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic e_busy, input logic e_done,
                           input logic [7:0] e_diff, input logic e_bout);
    check({tag, "_busy"}, 32'(busy), 32'(e_busy));
    check({tag, "_done"}, 32'(done), 32'(e_done));
    check({tag, "_diff"}, 32'(diff), 32'(e_diff));
    check({tag, "_bout"}, 32'(bout), 32'(e_bout));
  endtask

  // One full operation with a one-cycle start pulse; checks latency, result, hold.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tbin, input logic [7:0] e_diff, input logic e_bout);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      bin = 1'($urandom_range(0, 1));
      check({tag, "_busy_run"}, 32'(busy), 32'd1);
      check({tag, "_done_run"}, 32'(done), 32'd0);
      step();
    end
    check_out({tag, "_result"}, 1'b0, 1'b1, e_diff, e_bout);
    check({tag, "_state_done"}, 32'(state_dbg), 32'd2);
    step();
    check_out({tag, "_hold"}, 1'b0, 1'b0, e_diff, e_bout);
    check({tag, "_state_idle"}, 32'(state_dbg), 32'd0);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    #2;
    check_out("reset", 1'b0, 1'b0, 8'h00, 1'b0);
    check("reset_state", 32'(state_dbg), 32'd0);
    check("reset_w1_diff", 32'(diff1), 32'd0);
    check("reset_w1_bout", 32'(bout1), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // Basic subtraction and result hold
    run_op("op_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
    step();
    check("hold_later_diff", 32'(diff), 32'h1E);
    check("hold_later_done", 32'(done), 32'd0);

    // Underflow and borrow-in cases
    run_op("op_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run_op("op_80_7f_b1", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);

    // Start during RUN is ignored
    a = 8'hFF; b = 8'h01; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    a = 8'h00; start = 1'b1;
    step();
    start = 1'b0;
    check("ignore_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) step();
    check_out("ignore_result", 1'b0, 1'b1, 8'hFE, 1'b0);
    step();
    check_out("ignore_single_done", 1'b0, 1'b0, 8'hFE, 1'b0);

    // Asynchronous reset mid-RUN
    a = 8'h10; b = 8'h20; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("prereset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_out("midrun_reset", 1'b0, 1'b0, 8'h00, 1'b0);
    check("midrun_reset_state", 32'(state_dbg), 32'd0);
    step();
    rst = 1'b0;
    begin
      int seen_done;
      seen_done = 0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (done || busy) seen_done++;
      end
      check("no_done_after_reset", 32'(seen_done), 32'd0);
    end
    run_op("after_reset", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1);

    // Continuous start: one result every 9 cycles
    a = 8'h03; b = 8'h05; bin = 1'b0; start = 1'b1;
    step();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        check("stream_busy", 32'(busy), 32'd1);
        check("stream_nodone", 32'(done), 32'd0);
        step();
      end
      check_out("stream_result", 1'b0, 1'b1, 8'hFE, 1'b1);
      if (r == 2) start = 1'b0;
      step();
    end
    check_out("stream_end", 1'b0, 1'b0, 8'hFE, 1'b1);

    // WIDTH=1: 0 - 1 - 1 = 0 with borrow
    a1 = 1'b0; b1 = 1'b1; bin1 = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    check("w1_busy", 32'(busy1), 32'd1);
    check("w1_done_early", 32'(done1), 32'd0);
    step();
    check("w1_done", 32'(done1), 32'd1);
    check("w1_diff", 32'(diff1), 32'd0);
    check("w1_bout", 32'(bout1), 32'd1);
    step();
    check("w1_done_clear", 32'(done1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_sub_seq.md
Name: serial_sub_seq

Overview:
- Bit-serial subtraction sequencer that computes A - B - bin on WIDTH-bit operands.
- Reuses one 1-bit full-subtractor cell per clock, LSB first, with the borrow carried in a flop between bits.
- Sits in the COMBINATIONAL/arith area as the area-cheap alternative to a WIDTH-wide ripple subtractor.
- Uses a start/busy/done handshake toward the requesting logic.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend; captured on the accepted start.
- b  input  WIDTH  subtrahend; captured on the accepted start.
- bin  input  1  borrow-in; captured on the accepted start.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse; diff and bout are valid.
- diff  output  WIDTH  result (a - b - bin) mod 2^WIDTH.
- bout  output  1  final borrow-out; 1 iff a < b + bin (unsigned).

Behaviour:
- Bit cell, purely combinational, instantiated once inside the block:
  - d = x ^ y ^ c
  - bo = (~x & y) | (~(x ^ y) & c)
- State machine with three states: IDLE, RUN, DONE.
- Reset (async, rst=1):
  - state = IDLE; busy = 0; done = 0; diff = 0; bout = 0.
  - Operand shift registers, borrow flop and bit counter all cleared.
  - Takes effect immediately, including mid-RUN; the operation in flight is discarded and no done is produced.
- IDLE:
  - start=1 at a rising edge: capture a and b into shift registers, borrow flop = bin, counter = 0, go to RUN.
  - start=0: stay in IDLE; diff and bout keep their last values.
- RUN, once per edge:
  - Apply cell with x = a_sh[0], y = b_sh[0], c = borrow.
  - Shift d into diff from the MSB side (diff = {d, diff[WIDTH-1:1]}).
  - borrow = bo; shift a_sh and b_sh right by 1; counter + 1.
  - On the edge where counter == WIDTH-1: the final bit is written, bout = bo, go to DONE.
  - start is ignored in RUN; operand inputs are don't-care.
- DONE (lasts exactly one cycle):
  - done = 1; busy = 0; diff and bout hold the final result.
  - start=1: accepted as in IDLE (back-to-back operation); next state RUN.
  - otherwise next state IDLE.
- Output decode, registered or state-decoded, glitch-free:
  - busy = (state == RUN).
  - done = (state == DONE).
- Latency: start accepted at edge k -> busy high from k through k+WIDTH -> done high in the cycle after edge k+WIDTH. Total WIDTH+1 cycles from start to done.
- Throughput: one result per WIDTH+1 cycles when start is held high continuously.
- Result registers diff and bout:
  - Hold their value after DONE until the next accepted operation begins shifting.
  - In RUN, diff contents are partial results and must not be consumed.
- Counter width: clog2(WIDTH) bits, minimum 1. With WIDTH=1, RUN lasts exactly one cycle.
- Simultaneous start and rst: rst wins.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h3C, bin=0, start pulsed 1 cycle -> busy high 8 cycles, then done=1 for 1 cycle with diff=8'h1E, bout=0; done=0 afterwards and diff stays 8'h1E.
- a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1. Then a=8'h80, b=8'h7F, bin=1 -> diff=8'h00, bout=0.
- Start a=8'hFF, b=8'h01; pulse start again with a=8'h00 at RUN cycle 3 -> second request ignored; single done with diff=8'hFE, bout=0.
- Start a=8'h10, b=8'h20; assert rst at RUN cycle 4 for 1 cycle -> busy, done, diff, bout all 0 immediately; no done pulse follows. A new start after reset gives the correct result.
- start held high continuously with a=8'h03, b=8'h05, bin=0 -> done pulses every 9 cycles, each with diff=8'hFE, bout=1; busy low only during the done cycles.
- WIDTH=1: a=0, b=1, bin=1 -> done 2 cycles after start with diff=1'b0, bout=1.
